// File: rtl/ggt_batch_sequencer.sv
// Batch driver for ggt_top: walks N_PAIRS operand pairs from a synchronous ROM, runs one GCD per
// pair and stores each result in RAM. Optional WAIT watchdog and err_o port: define GGT_SEQ_TIMEOUT_EN.
module ggt_batch_sequencer #(
  parameter int unsigned N_PAIRS = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              run_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_zahl1_i,
  input  logic [DATA_W-1:0] rom_zahl2_i,
  output logic              ggt_start_o,
  output logic [DATA_W-1:0] ggt_zahl1_o,
  output logic [DATA_W-1:0] ggt_zahl2_o,
  input  logic              ggt_valid_i,
  input  logic [DATA_W-1:0] ggt_ergebnis_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_wren_o,
  output logic              busy_o,
  output logic              done_o,
`ifdef GGT_SEQ_TIMEOUT_EN
  output logic              err_o,
`endif
  output logic [ADDR_W:0]   count_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_WAIT, S_WRITE, S_NEXT, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_PAIRS - 1);

  if (N_PAIRS < 1 || N_PAIRS > (1 << ADDR_W)) begin : g_bad_npairs
    $error("ggt_batch_sequencer: N_PAIRS out of range");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("ggt_batch_sequencer: TIMEOUT must be at least 1");
  end

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   index_q;
  logic [ADDR_W:0]     count_q;
  logic [DATA_W-1:0]   zahl1_q, zahl2_q;
  logic [DATA_W-1:0]   result_q;
  logic                valid_q;
  logic                busy_q, done_q;

  logic                operand_zero;
  logic                accept;
  logic                last_pair;
  logic                tmo_hit;

  assign operand_zero = (rom_zahl1_i == '0) || (rom_zahl2_i == '0);
  // Only a fresh rising edge counts, so a valid still high from the previous pair is ignored.
  assign accept       = (state_q == S_WAIT) && ggt_valid_i && !valid_q;
  assign last_pair    = (index_q == LAST_IDX);

`ifdef GGT_SEQ_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_q;
  logic          err_q;

  assign tmo_hit = (state_q == S_WAIT) && !accept && (tmo_q == TMO_LAST);
  assign err_o   = err_q;
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (run_i) state_d = S_FETCH;
      S_FETCH:        state_d = S_LOAD;
      S_LOAD:         state_d = operand_zero ? S_WRITE : S_START;
      S_START:        state_d = S_WAIT;
      S_WAIT:         if (accept || tmo_hit) state_d = S_WRITE;
      S_WRITE:        state_d = S_NEXT;
      S_NEXT:         state_d = last_pair ? S_DONE : S_FETCH;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      index_q  <= '0;
      count_q  <= '0;
      zahl1_q  <= '0;
      zahl2_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef GGT_SEQ_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      valid_q <= ggt_valid_i;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (run_i) begin
            index_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
`ifdef GGT_SEQ_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          zahl1_q <= rom_zahl1_i;
          zahl2_q <= rom_zahl2_i;
          // With a zero operand the OR is already the GCD, so ggt_top is bypassed.
          if (operand_zero) result_q <= rom_zahl1_i | rom_zahl2_i;
        end
`ifdef GGT_SEQ_TIMEOUT_EN
        S_START: tmo_q <= '0;
`endif
        S_WAIT: begin
          if (accept) begin
            result_q <= ggt_ergebnis_i;
          end
`ifdef GGT_SEQ_TIMEOUT_EN
          else if (tmo_hit) begin
            result_q <= '1;
            err_q    <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
`endif
        end
        S_WRITE: count_q <= count_q + (ADDR_W+1)'(1);
        S_NEXT: begin
          if (last_pair) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            index_q <= index_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_addr_o  = index_q;
  assign ggt_start_o = (state_q == S_START);
  assign ggt_zahl1_o = zahl1_q;
  assign ggt_zahl2_o = zahl2_q;
  assign mem_addr_o  = index_q;
  assign mem_data_o  = result_q;
  assign mem_wren_o  = (state_q == S_WRITE);
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_ggt_batch_sequencer.sv
// Directed bench for ggt_batch_sequencer with behavioural ROM, ggt_top and result-RAM models.
// Define GGT_SEQ_TIMEOUT_EN to also exercise the watchdog path.
module tb_ggt_batch_sequencer;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned N_PAIRS = 3;
  localparam int unsigned LAT     = 6;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              run_i = 1'b0;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_zahl1_i, rom_zahl2_i;
  logic              ggt_start_o;
  logic [DATA_W-1:0] ggt_zahl1_o, ggt_zahl2_o;
  logic              ggt_valid_i;
  logic [DATA_W-1:0] ggt_ergebnis_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_wren_o;
  logic              busy_o, done_o;
  logic [ADDR_W:0]   count_o;
  logic              err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ggt_batch_sequencer #(
    .N_PAIRS (N_PAIRS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (20)
  ) u_dut (
    .clk            (clk),
    .rst_ni         (rst_ni),
    .run_i          (run_i),
    .rom_addr_o     (rom_addr_o),
    .rom_zahl1_i    (rom_zahl1_i),
    .rom_zahl2_i    (rom_zahl2_i),
    .ggt_start_o    (ggt_start_o),
    .ggt_zahl1_o    (ggt_zahl1_o),
    .ggt_zahl2_o    (ggt_zahl2_o),
    .ggt_valid_i    (ggt_valid_i),
    .ggt_ergebnis_i (ggt_ergebnis_i),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_wren_o     (mem_wren_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
`ifdef GGT_SEQ_TIMEOUT_EN
    .err_o          (err_o),
`endif
    .count_o        (count_o)
  );

`ifndef GGT_SEQ_TIMEOUT_EN
  assign err_o = 1'b0;
`endif

  // ---------------- models ----------------
  logic [DATA_W-1:0] rom1 [16];
  logic [DATA_W-1:0] rom2 [16];
  logic [DATA_W-1:0] ram  [16];
  int start_cnt = 0, wren_cnt = 0, overlap_cnt = 0;
  logic hold_mode = 1'b0, never_mode = 1'b0;
  int   gcnt;
  logic [DATA_W-1:0] ga, gb;

  function automatic logic [DATA_W-1:0] gcd(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  always @(posedge clk) begin
    rom_zahl1_i <= rom1[rom_addr_o];
    rom_zahl2_i <= rom2[rom_addr_o];
  end

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ggt_valid_i    <= 1'b0;
      ggt_ergebnis_i <= '0;
      gcnt           <= 0;
      ga             <= '0;
      gb             <= '0;
    end else if (ggt_start_o) begin
      gcnt <= LAT;
      ga   <= ggt_zahl1_o;
      gb   <= ggt_zahl2_o;
      if (!hold_mode) ggt_valid_i <= 1'b0;
    end else if (gcnt != 0) begin
      gcnt <= gcnt - 1;
      if (gcnt == 3) ggt_valid_i <= 1'b0;
      if (gcnt == 1 && !never_mode) begin
        ggt_valid_i    <= 1'b1;
        ggt_ergebnis_i <= gcd(ga, gb);
      end
    end else if (!hold_mode) begin
      ggt_valid_i <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_ni) begin
      if (ggt_start_o) start_cnt <= start_cnt + 1;
      if (mem_wren_o) begin
        ram[mem_addr_o] <= mem_data_o;
        wren_cnt <= wren_cnt + 1;
      end
      if (ggt_start_o && mem_wren_o) overlap_cnt <= overlap_cnt + 1;
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic set_rom(input logic [15:0] a0, b0, a1, b1, a2, b2);
    rom1[0] = a0; rom2[0] = b0;
    rom1[1] = a1; rom2[1] = b1;
    rom1[2] = a2; rom2[2] = b2;
  endtask

  task automatic do_run();
    @(negedge clk) run_i = 1'b1;
    @(negedge clk) run_i = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    for (int i = 0; i < maxc && !done_o; i++) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    checks++;
    if ({rom_addr_o, ggt_start_o, ggt_zahl1_o, ggt_zahl2_o, mem_addr_o, mem_data_o,
         mem_wren_o, busy_o, done_o, count_o, err_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b wren=%b busy=%b done=%b count=%0d data=%0d, all required 0",
               ggt_start_o, mem_wren_o, busy_o, done_o, count_o, mem_data_o);
    end
    @(negedge clk) rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || ggt_start_o !== 1'b0 || start_cnt !== 0) begin
      errors++;
      $display("FAIL idle_without_run: busy=%b done=%b starts=%0d, required 0 0 0", busy_o, done_o, start_cnt);
    end
  endtask

  task automatic test_first_batch();
    int s0;
    s0 = start_cnt;
    set_rom(16'd24255, 16'd12540, 16'd48, 16'd18, 16'd17, 16'd5);
    do_run();
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0 || count_o !== 0) begin
      errors++;
      $display("FAIL run_accept: busy=%b done=%b count=%0d, required 1 0 0", busy_o, done_o, count_o);
    end
    wait_done(200);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || count_o !== 3) begin
      errors++;
      $display("FAIL first_batch_done: done=%b busy=%b count=%0d, required 1 0 3", done_o, busy_o, count_o);
    end
    checks++;
    if (ram[0] !== 16'd165 || ram[1] !== 16'd6 || ram[2] !== 16'd1) begin
      errors++;
      $display("FAIL first_batch_ram: got %0d %0d %0d, required 165 6 1", ram[0], ram[1], ram[2]);
    end
    checks++;
    if (start_cnt - s0 !== 3) begin
      errors++;
      $display("FAIL first_batch_starts: got %0d, required 3", start_cnt - s0);
    end
  endtask

  task automatic test_main_batch();
    int s0, w0;
    s0 = start_cnt; w0 = wren_cnt;
    set_rom(16'd48, 16'd18, 16'd17, 16'd5, 16'd100, 16'd100);
    do_run();
    wait_done(200);
    checks++;
    if (ram[0] !== 16'd6 || ram[1] !== 16'd1 || ram[2] !== 16'd100) begin
      errors++;
      $display("FAIL main_batch_ram: got %0d %0d %0d, required 6 1 100", ram[0], ram[1], ram[2]);
    end
    checks++;
    if (start_cnt - s0 !== 3 || wren_cnt - w0 !== 3 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL main_batch_pulses: starts=%0d wrens=%0d done=%b, required 3 3 1",
               start_cnt - s0, wren_cnt - w0, done_o);
    end
  endtask

  task automatic test_zero_operands();
    int s0, w0;
    s0 = start_cnt; w0 = wren_cnt;
    set_rom(16'd0, 16'd35, 16'd0, 16'd0, 16'd35, 16'd0);
    do_run();
    wait_done(200);
    checks++;
    if (ram[0] !== 16'd35 || ram[1] !== 16'd0 || ram[2] !== 16'd35) begin
      errors++;
      $display("FAIL zero_ram: got %0d %0d %0d, required 35 0 35", ram[0], ram[1], ram[2]);
    end
    checks++;
    if (start_cnt - s0 !== 0 || wren_cnt - w0 !== 3 || count_o !== 3) begin
      errors++;
      $display("FAIL zero_pulses: starts=%0d wrens=%0d count=%0d, required 0 3 3",
               start_cnt - s0, wren_cnt - w0, count_o);
    end
  endtask

  task automatic test_stale_valid();
    int w0;
    w0 = wren_cnt;
    hold_mode = 1'b1;
    set_rom(16'd48, 16'd18, 16'd17, 16'd5, 16'd100, 16'd100);
    do_run();
    wait_done(300);
    hold_mode = 1'b0;
    checks++;
    if (ram[0] !== 16'd6 || ram[1] !== 16'd1 || ram[2] !== 16'd100) begin
      errors++;
      $display("FAIL stale_valid_ram: got %0d %0d %0d, required 6 1 100", ram[0], ram[1], ram[2]);
    end
    checks++;
    if (wren_cnt - w0 !== 3 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL stale_valid_writes: wrens=%0d done=%b, required 3 1", wren_cnt - w0, done_o);
    end
  endtask

  task automatic test_reset_midbatch();
    int s0, w0, n;
    set_rom(16'd12, 16'd8, 16'd21, 16'd14, 16'd27, 16'd18);
    s0 = start_cnt; w0 = wren_cnt;
    do_run();
    n = 0;
    while (start_cnt - s0 < 2 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if ({ggt_start_o, ggt_zahl1_o, ggt_zahl2_o, mem_addr_o, mem_data_o, mem_wren_o,
         busy_o, done_o, count_o, rom_addr_o} !== '0) begin
      errors++;
      $display("FAIL midbatch_reset_outputs: busy=%b count=%0d addr=%0d zahl1=%0d, all required 0",
               busy_o, count_o, mem_addr_o, ggt_zahl1_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wren_cnt - w0 !== 1 || ram[0] !== 16'd4) begin
      errors++;
      $display("FAIL midbatch_no_partial: wrens=%0d ram0=%0d, required 1 4", wren_cnt - w0, ram[0]);
    end
    rst_ni = 1'b1;
    set_rom(16'd30, 16'd12, 16'd21, 16'd14, 16'd27, 16'd18);
    do_run();
    n = 0;
    while (!mem_wren_o && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (mem_wren_o !== 1'b1 || mem_addr_o !== 0 || mem_data_o !== 16'd6 || count_o !== 0) begin
      errors++;
      $display("FAIL restart_first_write: wren=%b addr=%0d data=%0d count=%0d, required 1 0 6 0",
               mem_wren_o, mem_addr_o, mem_data_o, count_o);
    end
    @(negedge clk);
    checks++;
    if (count_o !== 1) begin
      errors++;
      $display("FAIL restart_count: got %0d, required 1", count_o);
    end
    wait_done(200);
    checks++;
    if (ram[0] !== 16'd6 || ram[1] !== 16'd7 || ram[2] !== 16'd9 || count_o !== 3) begin
      errors++;
      $display("FAIL restart_ram: got %0d %0d %0d count=%0d, required 6 7 9 3",
               ram[0], ram[1], ram[2], count_o);
    end
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = wren_cnt;
    set_rom(16'd9, 16'd6, 16'd10, 16'd4, 16'd49, 16'd14);
    do_run();
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b1 || count_o !== 0) begin
      errors++;
      $display("FAIL rerun_from_done: done=%b busy=%b count=%0d, required 0 1 0", done_o, busy_o, count_o);
    end
    repeat (12) @(negedge clk);
    do_run();
    wait_done(300);
    checks++;
    if (wren_cnt - w0 !== 3 || count_o !== 3 || ram[0] !== 16'd3 || ram[1] !== 16'd2 || ram[2] !== 16'd7) begin
      errors++;
      $display("FAIL run_ignored_busy: wrens=%0d count=%0d ram=%0d %0d %0d, required 3 3 3 2 7",
               wren_cnt - w0, count_o, ram[0], ram[1], ram[2]);
    end
    checks++;
    if (overlap_cnt !== 0) begin
      errors++;
      $display("FAIL start_wren_overlap: got %0d cycles, required 0", overlap_cnt);
    end
  endtask

`ifdef GGT_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    never_mode = 1'b1;
    set_rom(16'd7, 16'd3, 16'd9, 16'd6, 16'd5, 16'd5);
    do_run();
    n = 0;
    while (!ggt_start_o && n < 50) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_wren_o && n < 100);
    checks++;
    if (n !== 21 || mem_data_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL timeout_latency: write after %0d cycles data=%h, required 21 ffff", n, mem_data_o);
    end
    wait_done(500);
    checks++;
    if (ram[0] !== 16'hFFFF || ram[1] !== 16'hFFFF || ram[2] !== 16'hFFFF || err_o !== 1'b1 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_batch: ram=%h %h %h err=%b done=%b, required ffff ffff ffff 1 1",
               ram[0], ram[1], ram[2], err_o, done_o);
    end
    never_mode = 1'b0;
    do_run();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_on_run: got %b, required 0", err_o);
    end
    wait_done(300);
    checks++;
    if (ram[0] !== 16'd1 || ram[1] !== 16'd3 || ram[2] !== 16'd5 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL after_timeout_ram: got %0d %0d %0d err=%b, required 1 3 5 0",
               ram[0], ram[1], ram[2], err_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_batch();
    test_main_batch();
    test_zero_operands();
    test_stale_valid();
    test_reset_midbatch();
    test_back_to_back();
`ifdef GGT_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
